// File: rtl/enc_pkg.sv
// enc_pkg: shared types and defaults for the sequential 4-to-2 priority encoder.
package enc_pkg;
    typedef enum logic [0:0] {IDLE, HOLD} state_t;
    localparam int N_DEF = 4;
    localparam int W_DEF = 2;
endpackage

// File: rtl/encoder_4_to_2_seq_prio_pick.sv
// prio_pick: combinational priority search over vec starting at start.
// ENC_ROUND_ROBIN_EN selects ascending rotating search; otherwise descending from start-1.
module prio_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         any
);
    always_comb begin
        idx = '0;
        any = |vec;
        for (int i = N - 1; i >= 0; i--) begin
            int c;
`ifdef ENC_ROUND_ROBIN_EN
            c = (int'(start) + i) % N;
`else
            c = (int'(start) + N - 1 - i) % N;
`endif
            if (vec[c]) idx = W'(c);
        end
    end
endmodule

// File: rtl/encoder_4_to_2_seq.sv
// encoder_4_to_2_seq: sticky request capture with one-index-at-a-time valid/ready offer.
// ENC_ROUND_ROBIN_EN enables rotating priority; default is fixed highest-index priority.
module encoder_4_to_2_seq
    import enc_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         E,
    input  logic [N-1:0] A,
    output logic [W-1:0] Y,
    output logic         valid,
    input  logic         ready,
    output logic [N-1:0] pend
);
    state_t       state;
    logic [W-1:0] start;
    logic [W-1:0] pick;
    logic         any;
    logic         load;
    logic [N-1:0] clr;

    prio_pick #(.N(N), .W(W)) u_pick (
        .vec  (pend),
        .start(start),
        .idx  (pick),
        .any  (any)
    );

    assign valid = (state == HOLD);
    assign load  = any && (state == IDLE || ready);
    assign clr   = load ? (N'(1) << pick) : '0;

`ifdef ENC_ROUND_ROBIN_EN
    logic [W-1:0] rr_ptr;
    assign start = W'((int'(rr_ptr) + 1) % N);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_ptr <= W'(N - 1);
        else if (load) rr_ptr <= pick;
    end
`else
    assign start = '0;
`endif

    // a new capture ORs in after the clear so a same-cycle set wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            Y     <= '0;
            pend  <= '0;
        end else begin
            pend <= (pend & ~clr) | (E ? A : '0);
            if (load) begin
                Y     <= pick;
                state <= HOLD;
            end else if (state == HOLD && ready) begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_encoder_4_to_2_seq.sv
// tb_encoder_4_to_2_seq: directed self-checking bench for encoder_4_to_2_seq.
// Expected sequences follow ENC_ROUND_ROBIN_EN when defined.
module tb_encoder_4_to_2_seq;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       E;
    logic       ready;
    logic [3:0] A;
    logic [3:0] pend;
    logic [1:0] Y;
    logic       valid;
    int vecs = 0;
    int errs = 0;

    encoder_4_to_2_seq dut (
        .clk  (clk),
        .rst_n(rst_n),
        .E    (E),
        .A    (A),
        .Y    (Y),
        .valid(valid),
        .ready(ready),
        .pend (pend)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        E = 1'b0;
        A = 4'b0000;
        ready = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        E = 1'b1;
        A = 4'b1111;
        ready = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            vecs++;
            if ({valid, Y, pend} !== 7'b0_00_0000) begin
                errs++;
                $display("FAIL reset[%0d] got v=%b Y=%0d pend=%b want v=0 Y=0 pend=0000", i, valid, Y, pend);
            end
            step();
        end
        A = 4'b0000;
        E = 1'b0;
        ready = 1'b0;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_e_low;
        do_reset();
        E = 1'b0;
        A = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            step();
            vecs++;
            if (valid !== 1'b0 || pend !== 4'b0000) begin
                errs++;
                $display("FAIL e_low[%0d] got v=%b pend=%b want v=0 pend=0000", i, valid, pend);
            end
        end
        A = 4'b0000;
    endtask

    task automatic test_single;
        do_reset();
        E = 1'b1;
        A = 4'b0100;
        ready = 1'b1;
        step();
        vecs++;
        if (valid !== 1'b0 || pend !== 4'b0100) begin
            errs++;
            $display("FAIL single_capture got v=%b pend=%b want v=0 pend=0100", valid, pend);
        end
        A = 4'b0000;
        step();
        vecs++;
        if ({valid, Y, pend} !== 7'b1_10_0000) begin
            errs++;
            $display("FAIL single_offer got v=%b Y=%0d pend=%b want v=1 Y=2 pend=0000", valid, Y, pend);
        end
        step();
        vecs++;
        if (valid !== 1'b0 || pend !== 4'b0000) begin
            errs++;
            $display("FAIL single_done got v=%b pend=%b want v=0 pend=0000", valid, pend);
        end
    endtask

    task automatic test_hold_drain;
        logic [1:0] h [3];
`ifdef ENC_ROUND_ROBIN_EN
        h[0] = 2'd0; h[1] = 2'd1; h[2] = 2'd3;
`else
        h[0] = 2'd3; h[1] = 2'd1; h[2] = 2'd0;
`endif
        do_reset();
        E = 1'b1;
        A = 4'b1011;
        ready = 1'b0;
        step();
        vecs++;
        if (valid !== 1'b0 || pend !== 4'b1011) begin
            errs++;
            $display("FAIL hold_capture got v=%b pend=%b want v=0 pend=1011", valid, pend);
        end
        A = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            step();
            vecs++;
            if (valid !== 1'b1 || Y !== h[0]) begin
                errs++;
                $display("FAIL hold_stable[%0d] got v=%b Y=%0d want v=1 Y=%0d", i, valid, Y, h[0]);
            end
        end
        ready = 1'b1;
        for (int i = 1; i < 3; i++) begin
            step();
            vecs++;
            if (valid !== 1'b1 || Y !== h[i]) begin
                errs++;
                $display("FAIL hold_b2b[%0d] got v=%b Y=%0d want v=1 Y=%0d", i, valid, Y, h[i]);
            end
        end
        step();
        vecs++;
        if (valid !== 1'b0 || pend !== 4'b0000) begin
            errs++;
            $display("FAIL hold_done got v=%b pend=%b want v=0 pend=0000", valid, pend);
        end
    endtask

    task automatic test_repulse;
        do_reset();
        E = 1'b1;
        A = 4'b0100;
        ready = 1'b0;
        step();
        A = 4'b0000;
        step();
        vecs++;
        if ({valid, Y, pend} !== 7'b1_10_0000) begin
            errs++;
            $display("FAIL repulse_offer got v=%b Y=%0d pend=%b want v=1 Y=2 pend=0000", valid, Y, pend);
        end
        ready = 1'b1;
        A = 4'b0100;
        step();
        vecs++;
        if (valid !== 1'b0 || pend !== 4'b0100) begin
            errs++;
            $display("FAIL repulse_accept got v=%b pend=%b want v=0 pend=0100", valid, pend);
        end
        A = 4'b0000;
        ready = 1'b0;
        step();
        vecs++;
        if ({valid, Y, pend} !== 7'b1_10_0000) begin
            errs++;
            $display("FAIL repulse_reoffer got v=%b Y=%0d pend=%b want v=1 Y=2 pend=0000", valid, Y, pend);
        end
        ready = 1'b1;
        step();
        vecs++;
        if (valid !== 1'b0) begin
            errs++;
            $display("FAIL repulse_done got v=%b want v=0", valid);
        end
    endtask

    task automatic test_e_drain;
        logic [1:0] d [3];
`ifdef ENC_ROUND_ROBIN_EN
        d[0] = 2'd0; d[1] = 2'd1; d[2] = 2'd2;
`else
        d[0] = 2'd2; d[1] = 2'd1; d[2] = 2'd0;
`endif
        do_reset();
        E = 1'b1;
        A = 4'b0111;
        step();
        E = 1'b0;
        A = 4'b1000;
        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            vecs++;
            if (valid !== 1'b1 || Y !== d[i]) begin
                errs++;
                $display("FAIL e_drain[%0d] got v=%b Y=%0d want v=1 Y=%0d", i, valid, Y, d[i]);
            end
        end
        step();
        vecs++;
        if (valid !== 1'b0 || pend !== 4'b0000) begin
            errs++;
            $display("FAIL e_drain_done got v=%b pend=%b want v=0 pend=0000", valid, pend);
        end
        A = 4'b0000;
    endtask

    task automatic test_back_to_back;
        logic [1:0] s [5];
`ifdef ENC_ROUND_ROBIN_EN
        s[0] = 2'd0; s[1] = 2'd1; s[2] = 2'd2; s[3] = 2'd3; s[4] = 2'd0;
`else
        s[0] = 2'd3; s[1] = 2'd3; s[2] = 2'd3; s[3] = 2'd3; s[4] = 2'd3;
`endif
        do_reset();
        E = 1'b1;
        A = 4'b1111;
        ready = 1'b1;
        step();
        vecs++;
        if (valid !== 1'b0 || pend !== 4'b1111) begin
            errs++;
            $display("FAIL b2b_capture got v=%b pend=%b want v=0 pend=1111", valid, pend);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            vecs++;
            if (valid !== 1'b1 || Y !== s[i]) begin
                errs++;
                $display("FAIL b2b[%0d] got v=%b Y=%0d want v=1 Y=%0d", i, valid, Y, s[i]);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        vecs++;
        if ({valid, Y, pend} !== 7'b0_00_0000) begin
            errs++;
            $display("FAIL b2b_async_rst got v=%b Y=%0d pend=%b want v=0 Y=0 pend=0000", valid, Y, pend);
        end
        step();
        rst_n = 1'b1;
        step();
        vecs++;
        if (valid !== 1'b0 || pend !== 4'b1111) begin
            errs++;
            $display("FAIL b2b_recapture got v=%b pend=%b want v=0 pend=1111", valid, pend);
        end
        step();
        vecs++;
        if (valid !== 1'b1 || Y !== s[0]) begin
            errs++;
            $display("FAIL b2b_restart got v=%b Y=%0d want v=1 Y=%0d", valid, Y, s[0]);
        end
        A = 4'b0000;
        E = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        E = 1'b0;
        A = 4'b0000;
        ready = 1'b0;
        test_reset();
        test_e_low();
        test_single();
        test_hold_drain();
        test_repulse();
        test_e_drain();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
